// File: rtl/scanline_feed_arbiter_pkg.sv
// Shared video-mixer types: RGB555 pixel, feed FSM states and the frame START marker colour.
// Imported by the arbiter, its interface and the round-robin helper.
package vid_mixer_pkg;

    typedef logic [14:0] rgb15_t;

    typedef enum logic [1:0] {
        IDLE,
        MARKER,
        STREAM
    } feed_state_t;

    localparam rgb15_t cSTART_MARKER_RGB = 15'h0000;

    // One-hot grant vector for a 1-bit source index.
    function automatic logic [1:0] srcOneHot(input logic srcIdx);
        return srcIdx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/scanline_feed_arbiter_if.sv
// Pixel-domain bundle between the two renderers, the feed arbiter and the scanline converter.
// master = arbiter view, slave = surrounding environment (renderers + converter).
interface scanline_feed_arbiter_if;
    import vid_mixer_pkg::*;

    logic        iSRC0_REQ;
    logic        iSRC0_VALID;
    rgb15_t      iSRC0_RGB;
    logic        oSRC0_READY;

    logic        iSRC1_REQ;
    logic        iSRC1_VALID;
    rgb15_t      iSRC1_RGB;
    logic        oSRC1_READY;

    logic        oPIX_START;
    rgb15_t      oPIX_RGB;
    logic        oPIX_WRITE;
    logic        iPIX_FULL;

    logic [1:0]  oGRANT;
    logic        oFRAME_DONE;
    logic [15:0] oFRAME_CNT;

    modport master (
        input  iSRC0_REQ, iSRC0_VALID, iSRC0_RGB,
        input  iSRC1_REQ, iSRC1_VALID, iSRC1_RGB,
        input  iPIX_FULL,
        output oSRC0_READY, oSRC1_READY,
        output oPIX_START, oPIX_RGB, oPIX_WRITE,
        output oGRANT, oFRAME_DONE, oFRAME_CNT
    );

    modport slave (
        output iSRC0_REQ, iSRC0_VALID, iSRC0_RGB,
        output iSRC1_REQ, iSRC1_VALID, iSRC1_RGB,
        output iPIX_FULL,
        input  oSRC0_READY, oSRC1_READY,
        input  oPIX_START, oPIX_RGB, oPIX_WRITE,
        input  oGRANT, oFRAME_DONE, oFRAME_CNT
    );

endinterface

// File: rtl/scanline_feed_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; shared by the mixer layers.
// iLAST is the index of the previous winner, which loses a tie.
module rr_arb2 (
    input  logic [1:0] iREQ,
    input  logic       iLAST,
    output logic [1:0] oGRANT
);
    import vid_mixer_pkg::*;

    always_comb begin
        oGRANT = 2'b00;
        unique case (iREQ)
            2'b01:   oGRANT = 2'b01;
            2'b10:   oGRANT = 2'b10;
            2'b11:   oGRANT = srcOneHot(!iLAST);
            default: oGRANT = 2'b00;
        endcase
    end

endmodule

// File: rtl/scanline_feed_arbiter.sv
// Frame-granular arbiter feeding the scanline converter write port from two pixel sources.
// Each granted frame is a START marker followed by exactly pW*pH pixels from one source.
module scanline_feed_arbiter
    import vid_mixer_pkg::*;
#(
    parameter int unsigned pW         = 320,
    parameter int unsigned pH         = 240,
    parameter int unsigned pCNT_WIDTH = 17
) (
    input logic                     iPIX_CLK,
    input logic                     iRESET,
    scanline_feed_arbiter_if.master bus
);

    localparam longint unsigned cPIXELS = 64'(pW) * 64'(pH);
    localparam logic [pCNT_WIDTH-1:0] cLAST_PIX = pCNT_WIDTH'(cPIXELS - 64'd1);

    if (cPIXELS > (64'd1 << pCNT_WIDTH)) begin : gSizeCheck
        $fatal(1, "scanline_feed_arbiter: pW*pH does not fit in pCNT_WIDTH bits");
    end

    feed_state_t           state;
    logic                  lastGrant;
    logic [pCNT_WIDTH-1:0] pixCnt;
    logic [1:0]            arbGrant;

    logic   selValid;
    rgb15_t selRgb;
    logic   transfer;
    logic   lastPix;

    rr_arb2 uArb (
        .iREQ   ({bus.iSRC1_REQ, bus.iSRC0_REQ}),
        .iLAST  (lastGrant),
        .oGRANT (arbGrant)
    );

    // oGRANT is held for the whole frame, so it doubles as the source select.
    always_comb begin
        selValid = bus.oGRANT[1] ? bus.iSRC1_VALID : bus.iSRC0_VALID;
        selRgb   = bus.oGRANT[1] ? bus.iSRC1_RGB   : bus.iSRC0_RGB;
        transfer = (state == STREAM) && selValid && !bus.iPIX_FULL;
        lastPix  = transfer && (pixCnt == cLAST_PIX);
    end

    always_comb begin
        bus.oPIX_WRITE  = 1'b0;
        bus.oPIX_START  = 1'b0;
        bus.oPIX_RGB    = cSTART_MARKER_RGB;
        bus.oSRC0_READY = 1'b0;
        bus.oSRC1_READY = 1'b0;
        bus.oFRAME_DONE = lastPix;
        unique case (state)
            MARKER: begin
                bus.oPIX_START = 1'b1;
                bus.oPIX_WRITE = !bus.iPIX_FULL;
            end
            STREAM: begin
                bus.oPIX_WRITE  = transfer;
                bus.oPIX_RGB    = transfer ? selRgb : cSTART_MARKER_RGB;
                // READY is offered regardless of VALID so sources never deadlock on it.
                bus.oSRC0_READY = bus.oGRANT[0] && !bus.iPIX_FULL;
                bus.oSRC1_READY = bus.oGRANT[1] && !bus.iPIX_FULL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iPIX_CLK or posedge iRESET) begin
        if (iRESET) begin
            state          <= IDLE;
            lastGrant      <= 1'b1;
            pixCnt         <= '0;
            bus.oGRANT     <= 2'b00;
            bus.oFRAME_CNT <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|arbGrant) begin
                        bus.oGRANT <= arbGrant;
                        state      <= MARKER;
                    end
                end
                MARKER: begin
                    if (!bus.iPIX_FULL) begin
                        pixCnt <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        pixCnt <= pixCnt + pCNT_WIDTH'(1);
                        // Frame committed: REQ changes are ignored until the last pixel.
                        if (lastPix) begin
                            bus.oFRAME_CNT <= bus.oFRAME_CNT + 16'd1;
                            lastGrant      <= bus.oGRANT[1];
                            bus.oGRANT     <= 2'b00;
                            state          <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scanline_feed_arbiter.sv
// Bench for scanline_feed_arbiter: vector table, frame-level reference model with random and
// directed sequences, and a 65536-frame counter wrap run on a 1x1 instance.
module tb_scanline_feed_arbiter;
    import vid_mixer_pkg::*;

    localparam int unsigned cW = 4;
    localparam int unsigned cH = 2;
    localparam int cN = cW * cH;

    logic clk;
    logic rst;
    logic rstW;
    bit   wrapDone;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    scanline_feed_arbiter_if busM();
    scanline_feed_arbiter_if busW();

    scanline_feed_arbiter #(.pW(cW), .pH(cH), .pCNT_WIDTH(3)) dut (
        .iPIX_CLK (clk),
        .iRESET   (rst),
        .bus      (busM)
    );

    scanline_feed_arbiter #(.pW(1), .pH(1), .pCNT_WIDTH(1)) dutWrap (
        .iPIX_CLK (clk),
        .iRESET   (rstW),
        .bus      (busW)
    );

    typedef struct {
        logic r0, v0; rgb15_t g0;
        logic r1, v1; rgb15_t g1;
        logic full;
        logic w, s; rgb15_t rgb;
        logic rdy0, rdy1;
        logic [1:0] gnt;
        logic done;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    // Frame-level reference: owner, marker sent, pixels sent, previous winner, frames done.
    int          mOwner;
    bit          mMarked;
    int          mSent;
    int          mLast;
    logic [15:0] mCnt;

    rgb15_t      rgb0Next, rgb1Next;
    int          nMarkers, nPix, nDone;
    logic        lastW;
    logic [1:0]  markerGrants[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] packOut(input logic w, input logic s, input rgb15_t rgb,
                                            input logic r0, input logic r1,
                                            input logic [1:0] g, input logic d,
                                            input logic [15:0] c);
        return 64'({w, s, rgb, r0, r1, g, d, c});
    endfunction

    function automatic vec_t mk(input logic r0, input logic v0, input rgb15_t g0,
                                input logic r1, input logic v1, input rgb15_t g1,
                                input logic full, input logic w, input logic s,
                                input rgb15_t rgb, input logic rdy0, input logic rdy1,
                                input logic [1:0] gnt, input logic done,
                                input logic [15:0] cnt);
        vec_t v;
        v.r0 = r0; v.v0 = v0; v.g0 = g0; v.r1 = r1; v.v1 = v1; v.g1 = g1; v.full = full;
        v.w = w; v.s = s; v.rgb = rgb; v.rdy0 = rdy0; v.rdy1 = rdy1; v.gnt = gnt;
        v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic r0, input logic v0, input rgb15_t g0,
                         input logic r1, input logic v1, input rgb15_t g1, input logic f);
        busM.iSRC0_REQ = r0; busM.iSRC0_VALID = v0; busM.iSRC0_RGB = g0;
        busM.iSRC1_REQ = r1; busM.iSRC1_VALID = v1; busM.iSRC1_RGB = g1;
        busM.iPIX_FULL = f;
    endtask

    task automatic modelReset();
        mOwner = -1; mMarked = 0; mSent = 0; mLast = 1; mCnt = 16'd0;
        rgb0Next = 15'h0100; rgb1Next = 15'h4200;
    endtask

    task automatic clearStats();
        nMarkers = 0; nPix = 0; nDone = 0;
        markerGrants.delete();
    endtask

    task automatic actualOut(input logic maskRgb, output logic [63:0] a);
        a = packOut(busM.oPIX_WRITE, busM.oPIX_START, maskRgb ? busM.oPIX_RGB : 15'h0,
                    busM.oSRC0_READY, busM.oSRC1_READY, busM.oGRANT, busM.oFRAME_DONE,
                    busM.oFRAME_CNT);
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(0, 0, 15'h0, 0, 0, 15'h0, 0);
        @(posedge clk);
        #1;
        begin
            logic [63:0] a;
            actualOut(1'b1, a);
            chk("reset_state", a, 64'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
    endtask

    // One cycle against the model; inputs are applied at posedge+1, checked at negedge.
    task automatic mstep(input string name, input logic r0, input logic v0,
                         input logic r1, input logic v1, input logic f);
        logic [1:0] expG;
        logic expW, expS, expR0, expR1, expD, vSel;
        rgb15_t expRgb, g0, g1, gSel;
        logic [63:0] a;
        g0 = rgb0Next;
        g1 = rgb1Next;
        drive(r0, v0, g0, r1, v1, g1, f);
        @(negedge clk);
        expG = 2'b00; expW = 0; expS = 0; expR0 = 0; expR1 = 0; expD = 0; expRgb = 15'h0;
        if (mOwner >= 0) expG = (mOwner == 1) ? 2'b10 : 2'b01;
        if (mOwner >= 0 && !mMarked) begin
            expS = 1;
            expW = !f;
        end else if (mOwner >= 0) begin
            vSel   = (mOwner == 1) ? v1 : v0;
            gSel   = (mOwner == 1) ? g1 : g0;
            expR0  = (mOwner == 0) && !f;
            expR1  = (mOwner == 1) && !f;
            expW   = vSel && !f;
            expRgb = expW ? gSel : 15'h0;
            expD   = expW && (mSent == cN - 1);
        end
        actualOut(expW, a);
        chk(name, a, packOut(expW, expS, expRgb, expR0, expR1, expG, expD, mCnt));
        lastW = busM.oPIX_WRITE;
        if (busM.oPIX_WRITE && busM.oPIX_START) begin
            nMarkers++;
            markerGrants.push_back(busM.oGRANT);
        end
        if (busM.oPIX_WRITE && !busM.oPIX_START) nPix++;
        if (busM.oFRAME_DONE) nDone++;
        if (busM.oSRC0_READY && v0) rgb0Next = rgb0Next + 15'h1;
        if (busM.oSRC1_READY && v1) rgb1Next = rgb1Next + 15'h1;
        if (mOwner < 0) begin
            if (r0 && r1) mOwner = 1 - mLast;
            else if (r0) mOwner = 0;
            else if (r1) mOwner = 1;
            mMarked = 0;
        end else if (!mMarked) begin
            if (!f) begin
                mMarked = 1;
                mSent = 0;
            end
        end else if (expW) begin
            mSent++;
            if (expD) begin
                mCnt++;
                mLast = mOwner;
                mOwner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : mainTest
        logic [63:0] a;
        total = 0;
        bad = 0;
        rst = 1'b1;
        modelReset();
        clearStats();

        // Source 0 frame with FULL and VALID gaps and REQ dropped, then source 1 takes over.
        tbl.push_back(mk(1,1,15'h1234, 0,0,15'h0000, 0,  0,0,15'h0000, 0,0, 2'b00, 0, 16'd0));
        tbl.push_back(mk(1,1,15'h1234, 0,0,15'h0000, 1,  0,1,15'h0000, 0,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(1,1,15'h1234, 0,0,15'h0000, 0,  1,1,15'h0000, 0,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(1,1,15'h1234, 0,0,15'h0000, 0,  1,0,15'h1234, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(1,1,15'h1235, 0,0,15'h0000, 1,  0,0,15'h0000, 0,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(1,0,15'h1235, 0,0,15'h0000, 0,  0,0,15'h0000, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(1,1,15'h1235, 0,0,15'h0000, 0,  1,0,15'h1235, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(1,1,15'h1236, 0,0,15'h0000, 0,  1,0,15'h1236, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(0,1,15'h1237, 0,0,15'h0000, 0,  1,0,15'h1237, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(0,1,15'h1238, 0,0,15'h0000, 0,  1,0,15'h1238, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(0,1,15'h1239, 1,1,15'h2AAA, 0,  1,0,15'h1239, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(0,1,15'h123A, 1,1,15'h2AAA, 0,  1,0,15'h123A, 1,0, 2'b01, 0, 16'd0));
        tbl.push_back(mk(0,1,15'h123B, 1,1,15'h2AAA, 0,  1,0,15'h123B, 1,0, 2'b01, 1, 16'd0));
        tbl.push_back(mk(0,0,15'h0000, 1,1,15'h2AAA, 0,  0,0,15'h0000, 0,0, 2'b00, 0, 16'd1));
        tbl.push_back(mk(0,0,15'h0000, 1,1,15'h2AAA, 0,  1,1,15'h0000, 0,0, 2'b10, 0, 16'd1));
        tbl.push_back(mk(1,1,15'h1111, 1,1,15'h2AAA, 0,  1,0,15'h2AAA, 0,1, 2'b10, 0, 16'd1));

        doReset();
        foreach (tbl[i]) begin
            drive(tbl[i].r0, tbl[i].v0, tbl[i].g0, tbl[i].r1, tbl[i].v1, tbl[i].g1, tbl[i].full);
            @(negedge clk);
            actualOut(tbl[i].w, a);
            chk($sformatf("vec%0d", i), a,
                packOut(tbl[i].w, tbl[i].s, tbl[i].rgb, tbl[i].rdy0, tbl[i].rdy1,
                        tbl[i].gnt, tbl[i].done, tbl[i].cnt));
            @(posedge clk);
            #1;
        end

        // Both sources requesting continuously: grants must alternate starting with source 0.
        doReset();
        clearStats();
        for (int c = 0; c < 60 && nDone < 3; c++) mstep("rr_cycle", 1, 1, 1, 1, 0);
        chk("rr_frames", 64'(nDone), 64'd3);
        chk("rr_markers", 64'(nMarkers), 64'd3);
        chk("rr_pixels", 64'(nPix), 64'(3 * cN));
        if (markerGrants.size() == 3)
            chk("rr_grant_order", {58'h0, markerGrants[0], markerGrants[1], markerGrants[2]},
                64'b01_10_01);
        else
            chk("rr_grant_count", 64'(markerGrants.size()), 64'd3);

        // FULL held five cycles during MARKER and again five cycles mid-STREAM.
        doReset();
        clearStats();
        begin
            int fl = 0;
            int wrFull = 0;
            bit armed = 1;
            logic f;
            for (int c = 0; c < 60 && nDone == 0; c++) begin
                f = ((c >= 1) && (c <= 5)) || (fl > 0);
                if (fl > 0) fl--;
                mstep("full_cycle", 1, 1, 0, 0, f);
                if (f && lastW) wrFull++;
                if (armed && nPix == 3) begin
                    fl = 5;
                    armed = 0;
                end
            end
            chk("full_no_write", 64'(wrFull), 64'd0);
            chk("full_pixels", 64'(nPix), 64'(cN));
            chk("full_markers", 64'(nMarkers), 64'd1);
        end

        // Complete one frame, abandon the next after 5 pixels with an asynchronous reset.
        doReset();
        clearStats();
        for (int c = 0; c < 40 && nDone == 0; c++) mstep("pre_reset", 1, 1, 0, 0, 0);
        nPix = 0;
        for (int c = 0; c < 40 && nPix < 5; c++) mstep("pre_reset", 1, 1, 0, 0, 0);
        chk("pre_reset_cnt", 64'(busM.oFRAME_CNT), 64'd1);
        #2 rst = 1'b1;
        #1;
        actualOut(1'b1, a);
        chk("async_reset", a, 64'h0);
        @(negedge clk);
        chk("reset_hold_nowrite", 64'(busM.oPIX_WRITE), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        clearStats();
        for (int c = 0; c < 40 && nDone == 0; c++) mstep("post_reset", 1, 1, 0, 0, 0);
        chk("post_reset_markers", 64'(nMarkers), 64'd1);
        chk("post_reset_pixels", 64'(nPix), 64'(cN));
        mstep("post_reset_cnt", 0, 0, 0, 0, 0);
        chk("post_reset_frames", 64'(busM.oFRAME_CNT), 64'd1);

        // Random traffic against the model.
        doReset();
        clearStats();
        for (int i = 0; i < 1500; i++)
            mstep("random", logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 3) == 0));
        chk("random_progress", 64'(nDone > 10), 64'd1);

        wait (wrapDone);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // 1x1 frames back to back until the 16-bit frame counter wraps.
    initial begin : wrapTest
        int pulses;
        int cycles;
        int doubles;
        logic prevDone;
        pulses = 0;
        cycles = 0;
        doubles = 0;
        prevDone = 1'b0;
        wrapDone = 1'b0;
        rstW = 1'b1;
        busW.iSRC0_REQ = 1'b1; busW.iSRC0_VALID = 1'b1; busW.iSRC0_RGB = 15'h7C00;
        busW.iSRC1_REQ = 1'b0; busW.iSRC1_VALID = 1'b0; busW.iSRC1_RGB = 15'h0;
        busW.iPIX_FULL = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstW = 1'b0;
        while (pulses < 65536 && cycles < 65536 * 3 + 100) begin
            @(negedge clk);
            cycles++;
            if (busW.oFRAME_DONE) begin
                pulses++;
                if (prevDone) doubles++;
                if (pulses == 65535) chk("wrap_cnt_65534", 64'(busW.oFRAME_CNT), 64'd65534);
                if (pulses == 65536) chk("wrap_cnt_65535", 64'(busW.oFRAME_CNT), 64'd65535);
            end
            prevDone = busW.oFRAME_DONE;
        end
        chk("wrap_pulses", 64'(pulses), 64'd65536);
        @(negedge clk);
        chk("wrap_to_zero", 64'(busW.oFRAME_CNT), 64'd0);
        chk("wrap_single_pulse", 64'(doubles), 64'd0);
        wrapDone = 1'b1;
    end

endmodule

// File: doc/scanline_feed_arbiter.md
Name: scanline_feed_arbiter

Overview:
Frame-granular arbiter that shares the scanline converter's 320x240 write port between two pixel sources.
- Grants a whole frame to one requester.
- Inserts the START marker pixel at the beginning of each frame.
- Streams exactly pW*pH pixels, honouring the converter's full flag.
- Sits in the pixel clock domain, between the renderers and the scanline converter input.

Parameters:
pW, 320, active pixels per line
pH, 240, active lines per frame
pCNT_WIDTH, 17, width of pixel counter (must hold pW*pH-1)

Ports:
iPIX_CLK  in  1  pixel clock
iRESET  in  1  asynchronous active-high reset
iSRC0_REQ  in  1  source 0 has a frame pending (level)
iSRC0_VALID  in  1  source 0 pixel valid
iSRC0_RGB  in  15  source 0 pixel
oSRC0_READY  out  1  source 0 pixel accepted this cycle
iSRC1_REQ  in  1  source 1 has a frame pending (level)
iSRC1_VALID  in  1  source 1 pixel valid
iSRC1_RGB  in  15  source 1 pixel
oSRC1_READY  out  1  source 1 pixel accepted this cycle
oPIX_START  out  1  START marker flag to converter
oPIX_RGB  out  15  pixel to converter
oPIX_WRITE  out  1  write strobe to converter
iPIX_FULL  in  1  converter buffer full
oGRANT  out  2  one-hot current owner (00 = none)
oFRAME_DONE  out  1  one-cycle pulse on last pixel of a frame
oFRAME_CNT  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset: all outputs 0. State IDLE. Counters 0. Last-grant pointer = 1, so source 0 wins first.
- Reset is asynchronous. Asserting reset mid-frame abandons that frame.
  - No further writes occur.
  - The next frame after reset begins with a marker; the converter resyncs on it.
- State machine IDLE -> MARKER -> STREAM -> IDLE.
- IDLE:
  - If no REQ is asserted, stay in IDLE.
  - If exactly one REQ is asserted, grant that source.
  - If both are asserted, grant the source that is not the last grant (round robin).
  - oGRANT is set on the transition and held until STREAM exits.
  - The grant decision takes 1 cycle.
- MARKER:
  - oPIX_WRITE = !iPIX_FULL; oPIX_START = 1; oPIX_RGB = 0.
  - On a write: go to STREAM and clear the pixel counter.
  - While iPIX_FULL is high: hold.
- STREAM:
  - Transfer condition: sel_VALID && !iPIX_FULL.
  - On transfer: oPIX_WRITE = 1, oPIX_START = 0, oPIX_RGB = sel_RGB. These are combinational, zero latency.
  - oSRCn_READY = granted && state==STREAM && !iPIX_FULL. READY does not depend on VALID.
  - The non-granted source's READY is always 0.
  - Each transfer increments the pixel counter.
  - On the transfer with counter == pW*pH-1:
    - pulse oFRAME_DONE;
    - oFRAME_CNT += 1;
    - update the last-grant pointer;
    - clear oGRANT;
    - go to IDLE.
- A source dropping REQ mid-frame has no effect; the frame is committed until pW*pH pixels are sent.
- A VALID gap stalls the stream; no padding pixels are inserted.
- oPIX_WRITE is never asserted while iPIX_FULL = 1.
- Back-to-back frames: at least 1 idle cycle (IDLE) separates the last pixel from the next marker.
- Pixel counter is unsigned, pCNT_WIDTH bits, compared against the constant pW*pH-1.
- Elaboration check: pW*pH must fit in pCNT_WIDTH; otherwise a fatal error.

Decomposition:
- Shared package vid_mixer_pkg:
  - typedef rgb15_t (15-bit RGB555);
  - enum feed_state_t {IDLE, MARKER, STREAM};
  - constant cSTART_MARKER_RGB = 15'h0000.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last-grant.
  - Output: one-hot grant.
  - Purely combinational, reused by the mixer layers.

Test Plan:
- Frame from source 0 only (pW=4, pH=2). Stimulus: SRC0_REQ=1, VALID=1, RGB=0x1234..0x123B, FULL=0.
  - One write with START=1, RGB=0.
  - Then 8 writes with START=0 carrying 0x1234..0x123B.
  - FRAME_DONE pulses on the 8th pixel; FRAME_CNT=1; GRANT=00 the next cycle.
- Both REQ held high for 3 frames.
  - Grants alternate 01, 10, 01.
  - Each frame has exactly 1 marker + 8 pixels.
  - No interleaving of sources within a frame.
- iPIX_FULL asserted for 5 cycles mid-STREAM (and, separately, during MARKER).
  - WRITE=0 and READY=0 for those cycles.
  - The pixel sequence resumes unchanged; the frame total is still 8.
- SRC0 VALID toggling 1,0,0,1 during STREAM, and REQ dropped after the 3rd pixel.
  - Only valid cycles are written.
  - The frame still completes 8 pixels under grant 01.
- Reset pulse after pixel 5 of a frame.
  - All outputs are 0 immediately (asynchronous).
  - After release with REQ=1, the first write is a marker, then a full 8-pixel frame; FRAME_CNT restarts from 0.
- FRAME_CNT preloaded by running 65536 frames (pW=1, pH=1).
  - Wraps to 0; FRAME_DONE still pulses once per frame.
